// File: rtl/button_step_pkg.sv
// Shared types and helpers for the push-button step conditioner.
package button_step_pkg;

  typedef enum logic [2:0] {
    LOCKOUT    = 3'd0,
    IDLE       = 3'd1,
    PRESS_DB   = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } btn_state_t;

  // Width needed for one counter able to hold the largest of the three cycle counts.
  function automatic int calc_cnt_w(input int db_cycles, input int hold_cycles,
                                    input int repeat_cycles);
    int max_val;
    max_val = db_cycles;
    if (hold_cycles > max_val) max_val = hold_cycles;
    if (repeat_cycles > max_val) max_val = repeat_cycles;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_step_conditioner_if.sv
// Button-side bundle: raw button in, conditioned step/level/repeat status out.
interface button_step_conditioner_if;
  logic btn_raw;
  logic step;
  logic pressed;
  logic repeat_active;

  modport master (
    input  btn_raw,
    output step,
    output pressed,
    output repeat_active
  );

  modport slave (
    output btn_raw,
    input  step,
    input  pressed,
    input  repeat_active
  );
endinterface

// File: rtl/button_sync.sv
// Multi-flop synchroniser for the raw button; flops reset high so a button
// that looks held during reset is treated as held.
module button_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_s
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw level one stage deeper into the chain each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // Chain registers, forced to "held" by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_step_conditioner.sv
// Turns a bouncy push button into single-cycle step pulses with auto-repeat.
module button_step_conditioner
  import button_step_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 250000,
  parameter int HOLD_CYCLES   = 12500000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  button_step_conditioner_if.master bus
);

  localparam int CNT_W = calc_cnt_w(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             btn_s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             step_q, step_d;
  logic             pressed_q, pressed_d;
  logic             repeat_q, repeat_d;

  button_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(bus.btn_raw),
    .btn_s  (btn_s)
  );

  // Debounce, press detection and auto-repeat decisions for the next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    step_d    = 1'b0;
    pressed_d = pressed_q;
    repeat_d  = repeat_q;
    unique case (state_q)
      LOCKOUT: begin
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE: begin
        if (btn_s) begin
          if (DB_CYCLES == 1) begin
            state_d   = HELD;
            step_d    = 1'b1;
            pressed_d = 1'b1;
            timer_d   = HOLD_LOAD;
            cnt_d     = '0;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d   = HELD;
          step_d    = 1'b1;
          pressed_d = 1'b1;
          timer_d   = HOLD_LOAD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          if (DB_CYCLES == 1) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
            repeat_d  = 1'b0;
            cnt_d     = '0;
          end else begin
            state_d = RELEASE_DB;
            cnt_d   = CNT_ONE;
          end
        end else if (timer_q == CNT_ONE) begin
          timer_d = REPEAT_LOAD;
          if (REPEAT_CYCLES != 0) begin
            step_d   = 1'b1;
            repeat_d = 1'b1;
          end
        end else if (timer_q != '0) begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_d  = HELD;
          timer_d  = HOLD_LOAD;
          repeat_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          repeat_d  = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOCKOUT;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops every output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOCKOUT;
      cnt_q     <= '0;
      timer_q   <= '0;
      step_q    <= 1'b0;
      pressed_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      pressed_q <= pressed_d;
      repeat_q  <= repeat_d;
    end
  end

  assign bus.step          = step_q;
  assign bus.pressed       = pressed_q;
  assign bus.repeat_active = repeat_q;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Self-checking bench for button_step_conditioner against a run-length model.
module tb_button_step_conditioner;

  localparam int SYNC   = 2;
  localparam int DB     = 4;
  localparam int HOLD   = 10;
  localparam int REPEAT = 5;

  logic clk;
  logic rst;
  button_step_conditioner_if bus();

  button_step_conditioner #(
    .SYNC_STAGES  (SYNC),
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total;
  int    passed;
  string phase;

  // Reference model: the button level seen by the debouncer is the raw level
  // delayed through the synchroniser; a level is accepted once it has been
  // seen DB times in a row, and repeats fall on a fixed grid measured from
  // the edge where the current uninterrupted hold began.
  logic m_pipe [SYNC];
  logic m_run_val;
  int   m_run_len;
  bit   m_locked;
  bit   m_pressed;
  bit   m_rep;
  bit   m_step;
  int   m_anchor;
  int   m_edge;

  // Back to the power-on picture: synchroniser reads "held", nothing accepted.
  task automatic modelReset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b1;
    m_run_val = 1'b1;
    m_run_len = 0;
    m_locked  = 1'b1;
    m_pressed = 1'b0;
    m_rep     = 1'b0;
    m_step    = 1'b0;
    m_anchor  = 0;
    m_edge    = 0;
  endtask

  // One clock edge of the model, given the raw level sampled at that edge.
  task automatic modelEdge(input logic raw);
    logic s;
    int   d;
    s = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = raw;
    m_edge++;
    if (s == m_run_val) m_run_len++;
    else begin
      m_run_val = s;
      m_run_len = 1;
    end
    m_step = 1'b0;
    if (m_locked) begin
      if (!s && m_run_len >= DB) m_locked = 1'b0;
    end else if (!m_pressed) begin
      if (s && m_run_len >= DB) begin
        m_pressed = 1'b1;
        m_step    = 1'b1;
        m_anchor  = m_edge;
      end
    end else if (!s) begin
      if (m_run_len >= DB) begin
        m_pressed = 1'b0;
        m_rep     = 1'b0;
      end
    end else if (m_run_len == 1) begin
      m_anchor = m_edge;
      m_rep    = 1'b0;
    end else begin
      d = m_edge - m_anchor;
      if (REPEAT > 0 && d >= HOLD && ((d - HOLD) % REPEAT) == 0) begin
        m_step = 1'b1;
        m_rep  = 1'b1;
      end
    end
  endtask

  // Single comparison point: counts, and reports on mismatch.
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  // Compare all three outputs with the model.
  task automatic checkAll();
    checkOutput($sformatf("%s step @%0d", phase, m_edge), bus.step, m_step);
    checkOutput($sformatf("%s pressed @%0d", phase, m_edge), bus.pressed, m_pressed);
    checkOutput($sformatf("%s repeat_active @%0d", phase, m_edge), bus.repeat_active, m_rep);
  endtask

  // Drive one cycle of raw button and reset, advance the model, then check.
  task automatic applyStimulus(input logic raw, input logic r);
    @(negedge clk);
    bus.btn_raw = raw;
    rst         = r;
    @(posedge clk);
    if (r) modelReset();
    else   modelEdge(raw);
    #1;
    checkAll();
  endtask

  // Hold the raw button at one level for n cycles.
  task automatic holdLevel(input logic raw, input int n);
    for (int i = 0; i < n; i++) applyStimulus(raw, 1'b0);
  endtask

  logic [8:0] bounce;
  int         run;
  logic       lvl;
  bit         found;

  // Directed scenarios first, then randomized runs of bouncing levels.
  initial begin
    total  = 0;
    passed = 0;
    rst         = 1'b1;
    bus.btn_raw = 1'b0;
    modelReset();

    phase = "reset";
    #1;
    checkOutput("reset step", bus.step, 1'b0);
    checkOutput("reset pressed", bus.pressed, 1'b0);
    checkOutput("reset repeat_active", bus.repeat_active, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);

    phase = "lockout";
    holdLevel(1'b0, 10);

    phase = "clean_press";
    holdLevel(1'b1, 8);
    holdLevel(1'b0, 8);

    phase = "bounce";
    bounce = 9'b111101101;
    for (int i = 0; i < 9; i++) applyStimulus(bounce[i], 1'b0);
    holdLevel(1'b1, 3);
    holdLevel(1'b0, 8);

    phase = "auto_repeat";
    holdLevel(1'b1, 36);
    holdLevel(1'b0, 10);

    phase = "held_through_reset";
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    holdLevel(1'b1, 20);
    holdLevel(1'b0, 8);
    holdLevel(1'b1, 8);
    holdLevel(1'b0, 8);

    // Press until the first step, then run the repeat timer down to 1.
    phase = "reset_in_held";
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b0);
      found = bus.step;
    end
    checkOutput("reset_in_held first step seen", found, 1'b1);
    holdLevel(1'b1, HOLD - 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset step", bus.step, 1'b0);
    checkOutput("async reset pressed", bus.pressed, 1'b0);
    checkOutput("async reset repeat_active", bus.repeat_active, 1'b0);
    modelReset();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    holdLevel(1'b0, 8);

    phase = "random";
    lvl = 1'b0;
    for (int k = 0; k < 60; k++) begin
      lvl = ~lvl;
      run = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 32) : $urandom_range(1, 7);
      holdLevel(lvl, run);
    end
    holdLevel(1'b0, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
